memory_cycle: RTL and testbench

MEMORY_CYCLE -- requirements
Module: memory_cycle

---
 rtl/memory_cycle_pkg.sv | 13 +
 rtl/memory_cycle_data_memory.sv | 26 ++
 rtl/memory_cycle.sv | 165 ++++++++++++++++
 tb/tb_memory_cycle.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_cycle_pkg.sv
// Shared pipeline constants: funct3 load/store access encodings and the
// ResultSrc value that selects load data in writeback.
package memory_cycle_pkg;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

endpackage

// File: rtl/memory_cycle_data_memory.sv
// Word-organised data memory: byte-enable synchronous write, combinational
// read. Contents are never reset.
module data_memory #(
  parameter int DEPTH = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: store lane steering into data_memory, load truncation and the
// MEM/WB pipeline register. Optional build macro: MISALIGN_TRAP_EN.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic [2:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] PCTargetM,
  input  logic [31:0] Imm_Ext_M,
  output logic        RegWriteW,
  output logic [2:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] TruncateResultW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] PCTargetW,
  output logic [31:0] Imm_Ext_W
`ifdef MISALIGN_TRAP_EN
  ,output logic       MisalignW
`endif
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic [AW-1:0] w_index;
  logic [1:0]    w_off;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_we;
  logic [31:0]   w_rdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_trunc;
  logic          w_reg_write;
  logic          w_unused;

  // Address bits above the memory size are dropped, so accesses wrap.
  assign w_index  = ALU_ResultM[AW+1:2];
  assign w_off    = ALU_ResultM[1:0];
  assign w_unused = ^ALU_ResultM[31:AW+2];

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misalign;

  assign w_misalign = (((funct3M == F3_HALF) || (funct3M == F3_HALF_U)) && w_off[0])
                    || ((funct3M == F3_WORD) && (w_off != 2'b00));
`endif

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WriteDataM;
    case (funct3M)
      F3_BYTE: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{WriteDataM[7:0]}};
      end
      F3_HALF: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteDataM[15:0]}};
      end
      F3_WORD: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (w_misalign) w_be = 4'b0000;
`endif
  end

  // A store seen while reset is held must leave memory untouched.
  assign w_we = MemWriteM & ~rst;

  data_memory #(.DEPTH(DMEM_DEPTH)) u_dmem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (w_index),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_byte = w_rdata[7:0];
    case (w_off)
      2'd0:    w_byte = w_rdata[7:0];
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      default: w_byte = w_rdata[31:24];
    endcase
    w_half = w_off[1] ? w_rdata[31:16] : w_rdata[15:0];
    case (funct3M)
      F3_BYTE:   w_trunc = {{24{w_byte[7]}}, w_byte};
      F3_HALF:   w_trunc = {{16{w_half[15]}}, w_half};
      F3_BYTE_U: w_trunc = {24'h0, w_byte};
      F3_HALF_U: w_trunc = {16'h0, w_half};
      default:   w_trunc = w_rdata;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign w_reg_write = RegWriteM & ~((ResultSrcM == RESULT_SRC_LOAD) & w_misalign);
`else
  assign w_reg_write = RegWriteM;
`endif

  logic        r_reg_write;
  logic [2:0]  r_result_src;
  logic [4:0]  r_rd;
  logic [31:0] r_alu_result;
  logic [31:0] r_trunc;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_pc_target;
  logic [31:0] r_imm_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_result_src <= 3'b000;
      r_rd         <= 5'd0;
      r_alu_result <= 32'h0;
      r_trunc      <= 32'h0;
      r_pc_plus4   <= 32'h0;
      r_pc_target  <= 32'h0;
      r_imm_ext    <= 32'h0;
    end else begin
      r_reg_write  <= w_reg_write;
      r_result_src <= ResultSrcM;
      r_rd         <= RD_M;
      r_alu_result <= ALU_ResultM;
      r_trunc      <= w_trunc;
      r_pc_plus4   <= PCPlus4M;
      r_pc_target  <= PCTargetM;
      r_imm_ext    <= Imm_Ext_M;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_misalign & (MemWriteM | (ResultSrcM == RESULT_SRC_LOAD));
  end

  assign MisalignW = r_misalign;
`endif

  assign RegWriteW       = r_reg_write;
  assign ResultSrcW      = r_result_src;
  assign RD_W            = r_rd;
  assign ALU_ResultW     = r_alu_result;
  assign TruncateResultW = r_trunc;
  assign PCPlus4W        = r_pc_plus4;
  assign PCTargetW       = r_pc_target;
  assign Imm_Ext_W       = r_imm_ext;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: byte-array reference model checked every cycle,
// directed literal cases, then randomized traffic with sporadic resets.
module tb_memory_cycle;

  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteM = 1'b0;
  logic [2:0]  ResultSrcM = 3'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  funct3M = 3'b0;
  logic [4:0]  RD_M = 5'd0;
  logic [31:0] ALU_ResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] PCPlus4M = 32'h0;
  logic [31:0] PCTargetM = 32'h0;
  logic [31:0] Imm_Ext_M = 32'h0;
  logic        RegWriteW;
  logic [2:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] ALU_ResultW, TruncateResultW, PCPlus4W, PCTargetW, Imm_Ext_W;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  memory_cycle #(.DMEM_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .RegWriteM       (RegWriteM),
    .ResultSrcM      (ResultSrcM),
    .MemWriteM       (MemWriteM),
    .funct3M         (funct3M),
    .RD_M            (RD_M),
    .ALU_ResultM     (ALU_ResultM),
    .WriteDataM      (WriteDataM),
    .PCPlus4M        (PCPlus4M),
    .PCTargetM       (PCTargetM),
    .Imm_Ext_M       (Imm_Ext_M),
    .RegWriteW       (RegWriteW),
    .ResultSrcW      (ResultSrcW),
    .RD_W            (RD_W),
    .ALU_ResultW     (ALU_ResultW),
    .TruncateResultW (TruncateResultW),
    .PCPlus4W        (PCPlus4W),
    .PCTargetW       (PCTargetW),
    .Imm_Ext_W       (Imm_Ext_W)
`ifdef MISALIGN_TRAP_EN
    ,.MisalignW      (MisalignW)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flat little-endian byte array
  logic [7:0] mem_b [BYTES];

  function automatic int wbase(input logic [31:0] a);
    return (int'(a[11:0]) / 4) * 4;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b = wbase(a);
    return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0]  bv;
    logic [15:0] hv;
    int hb;
    bv = mem_b[int'(a[11:0])];
    hb = wbase(a) + (a[1] ? 2 : 0);
    hv = {mem_b[hb+1], mem_b[hb]};
    case (f3)
      3'b000:  return {{24{bv[7]}}, bv};
      3'b001:  return {{16{hv[15]}}, hv};
      3'b100:  return {24'h0, bv};
      3'b101:  return {16'h0, hv};
      default: return model_word(a);
    endcase
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b001 || f3 == 3'b101) return a[0];
    if (f3 == 3'b010) return (a[1:0] != 2'b00);
    return 1'b0;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int hb;
    case (f3)
      3'b000: mem_b[int'(a[11:0])] = d[7:0];
      3'b001: begin
        hb = wbase(a) + (a[1] ? 2 : 0);
        mem_b[hb]   = d[7:0];
        mem_b[hb+1] = d[15:8];
      end
      3'b010: for (int k = 0; k < 4; k++) mem_b[wbase(a)+k] = d[8*k +: 8];
      default: ;
    endcase
  endtask

  // Scoreboard: expectations formed at each edge, compared 1 time unit later
  logic        exp_rw, exp_mis, mis;
  logic [2:0]  exp_rs;
  logic [4:0]  exp_rd;
  logic [31:0] exp_alu, exp_tr, exp_pc4, exp_pct, exp_imm;

  always @(posedge clk) begin
    if (rst) begin
      {exp_rw, exp_mis, exp_rs, exp_rd} = '0;
      {exp_alu, exp_tr, exp_pc4, exp_pct, exp_imm} = '0;
    end else begin
      exp_rw  = RegWriteM;
      exp_rs  = ResultSrcM;
      exp_rd  = RD_M;
      exp_alu = ALU_ResultM;
      exp_tr  = model_load(funct3M, ALU_ResultM);
      exp_pc4 = PCPlus4M;
      exp_pct = PCTargetM;
      exp_imm = Imm_Ext_M;
      mis     = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis     = model_misaligned(funct3M, ALU_ResultM);
      exp_mis = mis && (MemWriteM || ResultSrcM == 3'b001);
      if (mis && ResultSrcM == 3'b001) exp_rw = 1'b0;
`else
      exp_mis = 1'b0;
`endif
      if (MemWriteM && !mis) model_store(funct3M, ALU_ResultM, WriteDataM);
    end
    #1;
    check("RegWriteW",       32'(RegWriteW),  32'(exp_rw));
    check("ResultSrcW",      32'(ResultSrcW), 32'(exp_rs));
    check("RD_W",            32'(RD_W),       32'(exp_rd));
    check("ALU_ResultW",     ALU_ResultW,     exp_alu);
    check("TruncateResultW", TruncateResultW, exp_tr);
    check("PCPlus4W",        PCPlus4W,        exp_pc4);
    check("PCTargetW",       PCTargetW,       exp_pct);
    check("Imm_Ext_W",       Imm_Ext_W,       exp_imm);
`ifdef MISALIGN_TRAP_EN
    check("MisalignW",       32'(MisalignW),  32'(exp_mis));
`endif
  end

  // Driver tasks
  task automatic drive(input logic we, input logic [2:0] rs, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic rw, input logic [4:0] rd);
    @(negedge clk);
    MemWriteM   = we;
    ResultSrcM  = rs;
    funct3M     = f3;
    ALU_ResultM = addr;
    WriteDataM  = wd;
    RegWriteM   = rw;
    RD_M        = rd;
    PCPlus4M    = $urandom;
    PCTargetM   = $urandom;
    Imm_Ext_M   = $urandom;
  endtask

  task automatic load_check(input string name, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, 3'b001, f3, addr, 32'h0, 1'b1, 5'd3);
    @(posedge clk);
    #2;
    check(name, TruncateResultW, exp);
  endtask

  initial begin
    for (int i = 0; i < BYTES; i++) mem_b[i] = 8'h00;
    @(posedge clk);
    #1;
    check("reset_RegWriteW", 32'(RegWriteW), 32'h0);
    check("reset_Truncate",  TruncateResultW, 32'h0);
    check("reset_PCPlus4W",  PCPlus4W, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Preload the low region that the random phase touches
    for (int w = 0; w < 16; w++) drive(1'b1, 3'b000, 3'b010, 32'(w * 4), $urandom, 1'b0, 5'd0);

    drive(1'b1, 3'b000, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0);
    load_check("lw_deadbeef", 3'b010, 32'h10, 32'hDEADBEEF);
    drive(1'b1, 3'b000, 3'b000, 32'h13, 32'h00000080, 1'b0, 5'd0);
    load_check("lb_signed",   3'b000, 32'h13, 32'hFFFFFF80);
    load_check("lbu",         3'b100, 32'h13, 32'h00000080);
    drive(1'b1, 3'b000, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0);
    drive(1'b1, 3'b000, 3'b001, 32'h12, 32'h00001234, 1'b0, 5'd0);
    load_check("lw_after_sh", 3'b010, 32'h10, 32'h1234BEEF);
    load_check("lh_upper",    3'b001, 32'h12, 32'h00001234);

`ifdef MISALIGN_TRAP_EN
    drive(1'b1, 3'b000, 3'b010, 32'h11, 32'hFFFFFFFF, 1'b0, 5'd0);
    @(posedge clk);
    #2;
    check("mis_store_flag", 32'(MisalignW), 32'h1);
    load_check("mis_store_nowrite", 3'b010, 32'h10, 32'h1234BEEF);
    drive(1'b0, 3'b001, 3'b010, 32'h12, 32'h0, 1'b1, 5'd9);
    @(posedge clk);
    #2;
    check("mis_load_rw",   32'(RegWriteW), 32'h0);
    check("mis_load_flag", 32'(MisalignW), 32'h1);
`endif

    drive(1'b1, 3'b000, 3'b010, 32'h1000, 32'h00000055, 1'b0, 5'd0);
    load_check("addr_wrap", 3'b010, 32'h0, 32'h00000055);

    // Asynchronous reset mid-cycle, with a store held during reset
    drive(1'b0, 3'b000, 3'b000, 32'h0, 32'h0, 1'b1, 5'd5);
    @(posedge clk);
    #2;
    check("pre_rst_rw", 32'(RegWriteW), 32'h1);
    check("pre_rst_rd", 32'(RD_W), 32'd5);
    #1;
    rst = 1'b1;
    MemWriteM = 1'b1;
    funct3M = 3'b010;
    ALU_ResultM = 32'h10;
    WriteDataM = 32'h0;
    #1;
    check("async_rst_rw", 32'(RegWriteW), 32'h0);
    check("async_rst_rd", 32'(RD_W), 32'h0);
    @(posedge clk);
    drive(1'b0, 3'b001, 3'b010, 32'h10, 32'h0, 1'b1, 5'd7);
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("rst_store_blocked", TruncateResultW, 32'h1234BEEF);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        we, rw;
      logic [2:0]  rs;
      logic [31:0] addr;
      int kind;
      kind = $urandom_range(0, 2);
      addr = $urandom;
      addr[11:6] = '0;
      rs = 3'($urandom_range(0, 7));
      if (rs == 3'b001) rs = 3'b000;
      we = (kind == 0);
      rw = 1'($urandom);
      if (kind == 1) begin
        rs = 3'b001;
        rw = 1'b1;
      end
      drive(we, rs, 3'($urandom_range(0, 7)), addr, $urandom, rw, 5'($urandom));
      rst = ($urandom_range(0, 39) == 0);
    end
    drive(1'b0, 3'b000, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    rst = 1'b0;
    @(posedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
